// File: rtl/mdu.sv
// Multiply/divide unit with architectural HI/LO and a fixed-latency busy window.
// Divide support (DIV/DIVU) is compiled in only when MDU_DIV_EN is defined.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, state_nxt;

    logic [CNT_W-1:0] cnt, lat;
    logic [31:0]      temp_hi, temp_lo;
    logic [31:0]      res_hi, res_lo;
    logic [63:0]      prod_s, prod_u;
    logic             is_mul, is_div, launch, commit, idle_start;

    // Sign-extended operands: the low 64 bits of the product are the signed product.
    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign prod_u = {32'b0, A} * {32'b0, B};

    assign is_mul = (op == 3'd0) || (op == 3'd1);

`ifdef MDU_DIV_EN
    logic [31:0] q_s, r_s, q_u, r_u;
    assign is_div = (op == 3'd2) || (op == 3'd3);

    // Zero divisor and the single signed overflow case are defined explicitly.
    always_comb begin
        q_s = 32'hFFFF_FFFF;
        r_s = A;
        q_u = 32'hFFFF_FFFF;
        r_u = A;
        if (B != 32'd0) begin
            q_u = A / B;
            r_u = A % B;
            if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
                q_s = 32'h8000_0000;
                r_s = 32'd0;
            end else begin
                q_s = $signed(A) / $signed(B);
                r_s = $signed(A) % $signed(B);
            end
        end
    end
`else
    assign is_div = 1'b0;
`endif

    always_comb begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
        lat    = CNT_W'(MULT_CYCLES);
        case (op)
            3'd1: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
`ifdef MDU_DIV_EN
            3'd2: begin
                res_hi = r_s;
                res_lo = q_s;
                lat    = CNT_W'(DIV_CYCLES);
            end
            3'd3: begin
                res_hi = r_u;
                res_lo = q_u;
                lat    = CNT_W'(DIV_CYCLES);
            end
`endif
            default: ;
        endcase
    end

    assign idle_start = (state == IDLE) && start;
    assign launch     = idle_start && (is_mul || is_div);
    assign commit     = (state == BUSY) && (cnt == CNT_W'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (launch) state_nxt = BUSY;
            BUSY:    if (commit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == BUSY);
    end

    // Result is latched at issue so operand changes during BUSY cannot leak in.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            temp_hi <= '0;
            temp_lo <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            if (launch) begin
                cnt     <= lat;
                temp_hi <= res_hi;
                temp_lo <= res_lo;
            end else if (state == BUSY) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (commit) begin
                hi <= temp_hi;
                lo <= temp_lo;
            end else if (idle_start && op == 3'd4) begin
                hi <= A;
            end else if (idle_start && op == 3'd5) begin
                lo <= A;
            end
        end
    end
endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: an arithmetic reference model checked every cycle,
// plus literal expectations for the worked examples.
module tb_mdu;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A, B;
    logic        busy;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
        .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending result plus remaining busy cycles.
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    int          m_left;

    task automatic model_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                            output int lat, output logic [31:0] rh, output logic [31:0] rl);
        longint          ps, q, r;
        longint unsigned pu;
        lat = 0; rh = 0; rl = 0;
        case (o)
            3'd0: begin
                ps = longint'($signed(a)) * longint'($signed(b));
                rh = ps[63:32]; rl = ps[31:0]; lat = 5;
            end
            3'd1: begin
                pu = longint'(a) * longint'(b);
                rh = pu[63:32]; rl = pu[31:0]; lat = 5;
            end
`ifdef MDU_DIV_EN
            3'd2: begin
                lat = 10;
                if (b == 0) begin rl = 32'hFFFF_FFFF; rh = a; end
                else begin
                    q = longint'($signed(a)) / longint'($signed(b));
                    r = longint'($signed(a)) - q * longint'($signed(b));
                    rl = q[31:0]; rh = r[31:0];
                end
            end
            3'd3: begin
                lat = 10;
                if (b == 0) begin rl = 32'hFFFF_FFFF; rh = a; end
                else begin rl = a / b; rh = a - (a / b) * b; end
            end
`endif
            default: lat = 0;
        endcase
    endtask

    always @(posedge clk or negedge reset) begin
        int          l;
        logic [31:0] rh, rl;
        if (!reset) begin
            m_hi = 0; m_lo = 0; m_left = 0; p_hi = 0; p_lo = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin m_hi = p_hi; m_lo = p_lo; end
        end else if (start) begin
            if (op == 3'd4) m_hi = A;
            else if (op == 3'd5) m_lo = A;
            else begin
                model_op(op, A, B, l, rh, rl);
                if (l > 0) begin m_left = l; p_hi = rh; p_lo = rl; end
            end
        end
    end

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            chk("model_busy", {31'b0, busy}, {31'b0, m_left > 0});
            chk("model_hi", hi, m_hi);
            chk("model_lo", lo, m_lo);
        end
    end

    // Caller is at a negedge; start is sampled at the following posedge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; A = a; B = b;
        @(negedge clk);
        start = 1'b0; op = 3'($urandom_range(0, 7)); A = $urandom; B = $urandom;
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int exp_cyc);
        int n = 0;
        issue(o, a, b);
        while (busy === 1'b1 && n < 200) begin n++; @(negedge clk); end
        chk({name, "_busy_len"}, 32'(n), 32'(exp_cyc));
    endtask

    initial begin
        int n;
        reset = 1'b0; start = 1'b0; op = 3'd0; A = 0; B = 0;
        #3;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // First start right after reset release
        run_op("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, 5);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);

        run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
        chk("multu_hi", hi, 32'hFFFF_FFFE);
        chk("multu_lo", lo, 32'h0000_0001);

        issue(3'd4, 32'h1234_5678, 32'd0);
        chk("mthi_hi", hi, 32'h1234_5678);
        chk("mthi_lo", lo, 32'h0000_0001);
        chk("mthi_busy", {31'b0, busy}, 32'd0);

        // MTLO during a MULT is dropped
        issue(3'd0, 32'd7, 32'hFFFF_FFFD);
        issue(3'd5, 32'h1234_5678, 32'd0);
        n = 0;
        while (busy === 1'b1 && n < 200) begin n++; @(negedge clk); end
        chk("mtlo_ign_hi", hi, 32'hFFFF_FFFF);
        chk("mtlo_ign_lo", lo, 32'hFFFF_FFEB);

`ifdef MDU_DIV_EN
        run_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 10);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        run_op("divu0", 3'd3, 32'd100, 32'd0, 10);
        chk("divu0_hi", hi, 32'd100);
        chk("divu0_lo", lo, 32'hFFFF_FFFF);
        run_op("divovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10);
        chk("divovf_hi", hi, 32'd0);
        chk("divovf_lo", lo, 32'h8000_0000);
        run_op("div10", 3'd2, 32'd10, 32'd2, 10);
        chk("div10_hi", hi, 32'd0);
        chk("div10_lo", lo, 32'd5);
`else
        run_op("div_off", 3'd2, 32'd10, 32'd2, 0);
        chk("div_off_hi", hi, 32'hFFFF_FFFF);
        chk("div_off_lo", lo, 32'hFFFF_FFEB);
        run_op("divu_off", 3'd3, 32'd100, 32'd0, 0);
        chk("divu_off_lo", lo, 32'hFFFF_FFEB);
`endif

        issue(3'd5, 32'hCAFE_BABE, 32'd0);
        run_op("rsv6", 3'd6, 32'd1, 32'd1, 0);
        run_op("rsv7", 3'd7, 32'd2, 32'd3, 0);
        chk("rsv_lo", lo, 32'hCAFE_BABE);

        // Back-to-back: second start in the cycle after busy falls
        run_op("b2b_a", 3'd1, 32'd3, 32'd4, 5);
        chk("b2b_a_lo", lo, 32'd12);
        run_op("b2b_b", 3'd0, 32'd2, 32'hFFFF_FFFF, 5);
        chk("b2b_b_hi", hi, 32'hFFFF_FFFF);
        chk("b2b_b_lo", lo, 32'hFFFF_FFFE);

        // Reset on busy cycle 3 aborts the multiply
        issue(3'd0, 32'd4, 32'd5);
        @(negedge clk);
        @(negedge clk);
        chk("pre_abort_busy", {31'b0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_abort_hi", hi, 32'd0);
        chk("post_abort_lo", lo, 32'd0);
        run_op("mult45", 3'd0, 32'd4, 32'd5, 5);
        chk("mult45_lo", lo, 32'd20);
        chk("mult45_hi", hi, 32'd0);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 The block SHALL have these parameters:
- MULT_CYCLES, default 5, busy duration for MULT/MULTU.
- DIV_CYCLES, default 10, busy duration for DIV/DIVU.
REQ-002 The block SHALL have these ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  E-stage pulse; op/A/B valid this cycle.
- op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6-7 reserved.
- A  input  32  forwarded rs operand.
- B  input  32  forwarded rt operand.
- busy  output  1  operation in flight.
- hi  output  32  architectural HI register.
- lo  output  32  architectural LO register.

Function
REQ-003 The block SHALL be a two-state FSM, IDLE and BUSY, with a down-counter cnt sized to hold max(MULT_CYCLES, DIV_CYCLES).
REQ-004 In IDLE, start=1 with op 0-3 at edge N SHALL capture the result into internal temp registers, load cnt with the op's latency L, and enter BUSY.
REQ-005 busy SHALL be 1 for exactly L cycles, from after edge N through edge N+L.
REQ-006 At edge N+L, hi/lo SHALL take the temp result and the FSM SHALL return to IDLE.
REQ-007 During BUSY, hi/lo SHALL hold their previous values.
REQ-008 MULT SHALL produce the signed 64-bit product, {hi,lo} = $signed(A)*$signed(B).
REQ-009 MULTU SHALL produce the unsigned 64-bit product.
REQ-010 DIV SHALL give lo = signed quotient truncated toward zero and hi = remainder with the sign of A.
REQ-011 DIVU SHALL give the unsigned quotient and remainder.
REQ-012 Division by zero (B=0) SHALL give lo=32'hFFFFFFFF and hi=A, with normal latency.
REQ-013 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL give lo=32'h80000000 and hi=0.
REQ-014 In IDLE, start=1 with op=4 (MTHI) SHALL write hi=A at that edge, leave lo unchanged and keep busy=0.
REQ-015 In IDLE, start=1 with op=5 (MTLO) SHALL write lo=A at that edge, leave hi unchanged and keep busy=0.
REQ-016 start=1 with op 6 or 7 SHALL be ignored.
REQ-017 start=1 while busy=1 SHALL be ignored for every op.
REQ-018 A new start in the cycle after busy falls SHALL be accepted.
REQ-019 The hazard unit SHALL stall D when the D-stage instruction is any MDU op or MFHI/MFLO and (start | busy)=1. This is a system contract; the block does not enforce it.
REQ-020 Operand changes on A/B after the start edge SHALL NOT affect the result.

Reset
REQ-021 reset=0 SHALL immediately force state=IDLE, cnt=0, busy=0, hi=0, lo=0 and temp=0, independent of clk.
REQ-022 Reset asserted mid-operation SHALL abort the operation; no partial result reaches hi/lo.
REQ-023 The first start SHALL be accepted at the first rising edge after reset returns to 1.

Configuration
REQ-024 The macro MDU_DIV_EN SHALL control divide support.
REQ-025 With MDU_DIV_EN defined, DIV and DIVU SHALL behave per REQ-010 to REQ-013.
REQ-026 Without MDU_DIV_EN, op 2 and op 3 SHALL be treated as reserved: no busy, and hi/lo unchanged. No divider logic SHALL be synthesised, and DIV_CYCLES SHALL be unused.

Verification
REQ-027 MULT, A=32'hFFFFFFFE (-2), B=3 -> busy high 5 cycles, then hi=32'hFFFFFFFF, lo=32'hFFFFFFFA.
REQ-028 MULTU, A=32'hFFFFFFFF, B=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001 after 5 cycles.
REQ-029 DIV, A=-7 (32'hFFFFFFF9), B=2 -> busy 10 cycles, then lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
- DIVU, A=100, B=0 -> lo=32'hFFFFFFFF, hi=100.
REQ-030 MTHI, A=32'h12345678, in IDLE -> hi=32'h12345678 at the next edge, busy stays 0.
- MTLO, A=32'h12345678, issued during a MULT -> ignored; the MULT result is committed unchanged.
REQ-031 Start MULT, A=4, B=5; assert reset on busy cycle 3 -> busy=0, hi=lo=0 immediately, and they stay 0 after release.
- Then MULT, A=4, B=5 -> lo=20 after 5 cycles.
REQ-032 With MDU_DIV_EN undefined, DIV, A=10, B=2 -> busy never asserts and hi/lo keep their prior values.
